// File: rtl/sync_filt_edge_if.sv
// sync_filt_edge_if
//   Bundles the per-channel level/event signals of the input conditioner.
//   All vectors are CH_NUM bits wide, one bit per channel.
//   Ports (signals):
//     async_in   - asynchronous level inputs            (master -> slave)
//     evt_clr    - per-channel clear of evt_sticky      (master -> slave)
//     sync_out   - synchronizer output, unfiltered      (slave -> master)
//     filt_out   - debounced level                      (slave -> master)
//     rise_pls   - one-cycle pulse on filt_out 0->1     (slave -> master)
//     fall_pls   - one-cycle pulse on filt_out 1->0     (slave -> master)
//     evt_sticky - latched rise/fall event flag         (slave -> master)
interface sync_filt_edge_if #(
  parameter int CH_NUM = 4
);
  logic [CH_NUM-1:0] async_in;
  logic [CH_NUM-1:0] evt_clr;
  logic [CH_NUM-1:0] sync_out;
  logic [CH_NUM-1:0] filt_out;
  logic [CH_NUM-1:0] rise_pls;
  logic [CH_NUM-1:0] fall_pls;
  logic [CH_NUM-1:0] evt_sticky;

  modport master (
    output async_in,
    output evt_clr,
    input  sync_out,
    input  filt_out,
    input  rise_pls,
    input  fall_pls,
    input  evt_sticky
  );

  modport slave (
    input  async_in,
    input  evt_clr,
    output sync_out,
    output filt_out,
    output rise_pls,
    output fall_pls,
    output evt_sticky
  );
endinterface

// File: rtl/sync_filt_edge.sv
// sync_filt_edge
//   Multi-channel input conditioner: per channel an ASYNC_REG synchronizer
//   chain, a consecutive-sample glitch filter, registered rise/fall pulses
//   and a sticky event flag. Channels are fully independent.
//   Ports:
//     clk    - sole clock
//     rst_n  - synchronous active-low reset
//     bus    - sync_filt_edge_if slave modport (async_in, evt_clr in;
//              sync_out, filt_out, rise_pls, fall_pls, evt_sticky out)
module sync_filt_edge #(
  parameter int                CH_NUM      = 4,
  parameter int                SYNC_STAGES = 2,
  parameter int                FILT_CNT    = 4,
  parameter logic [CH_NUM-1:0] RST_VAL     = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  sync_filt_edge_if.slave bus
);

  localparam int             CW     = $clog2(FILT_CNT + 1);
  localparam logic [CW-1:0]  CNT_TC = CW'(FILT_CNT - 1);

  (* ASYNC_REG = "TRUE" *) logic [CH_NUM-1:0] sync_q [SYNC_STAGES];
  logic [CH_NUM-1:0] sync_d [SYNC_STAGES];

  logic [CW-1:0]     cnt_q [CH_NUM];
  logic [CW-1:0]     cnt_d [CH_NUM];
  logic [CH_NUM-1:0] filt_q, filt_d;
  logic [CH_NUM-1:0] rise_q, rise_d;
  logic [CH_NUM-1:0] fall_q, fall_d;
  logic [CH_NUM-1:0] sticky_q, sticky_d;
  logic [CH_NUM-1:0] upd;
  logic [CH_NUM-1:0] sync_last;

  assign sync_last = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d[0] = bus.async_in;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  // Counter tracks how many consecutive cycles sync_last has disagreed with
  // filt_q; any agreeing sample discards the partial count.
  always_comb begin
    upd    = '0;
    filt_d = filt_q;
    for (int i = 0; i < CH_NUM; i++) begin
      cnt_d[i] = '0;
      if (sync_last[i] != filt_q[i]) begin
        if (cnt_q[i] == CNT_TC) begin
          filt_d[i] = sync_last[i];
          upd[i]    = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Pulses are registered alongside filt_q so they line up with the first
  // cycle the new level is visible; set dominates clear on the sticky flag.
  always_comb begin
    rise_d   = upd & sync_last;
    fall_d   = upd & ~sync_last;
    sticky_d = (sticky_q & ~bus.evt_clr) | rise_d | fall_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= RST_VAL;
      end
      for (int i = 0; i < CH_NUM; i++) begin
        cnt_q[i] <= '0;
      end
      filt_q   <= RST_VAL;
      rise_q   <= '0;
      fall_q   <= '0;
      sticky_q <= '0;
    end else begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_d[k];
      end
      for (int i = 0; i < CH_NUM; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      filt_q   <= filt_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      sticky_q <= sticky_d;
    end
  end

  assign bus.sync_out   = sync_last;
  assign bus.filt_out   = filt_q;
  assign bus.rise_pls   = rise_q;
  assign bus.fall_pls   = fall_q;
  assign bus.evt_sticky = sticky_q;

endmodule

// File: tb/tb_sync_filt_edge.sv
// tb_sync_filt_edge
//   Directed checks of sync_filt_edge with three instances:
//     dut0 - defaults (4 ch, 2 stages, FILT_CNT=4, RST_VAL=0)
//     dut1 - RST_VAL=4'b1111
//     dut2 - CH_NUM=1, SYNC_STAGES=3, FILT_CNT=1
module tb_sync_filt_edge;

  logic clk = 1'b0;
  logic rst0_n, rst1_n, rst2_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  sync_filt_edge_if #(.CH_NUM(4)) bus0 ();
  sync_filt_edge_if #(.CH_NUM(4)) bus1 ();
  sync_filt_edge_if #(.CH_NUM(1)) bus2 ();

  sync_filt_edge #(.CH_NUM(4), .SYNC_STAGES(2), .FILT_CNT(4), .RST_VAL(4'b0000))
    dut0 (.clk(clk), .rst_n(rst0_n), .bus(bus0));
  sync_filt_edge #(.CH_NUM(4), .SYNC_STAGES(2), .FILT_CNT(4), .RST_VAL(4'b1111))
    dut1 (.clk(clk), .rst_n(rst1_n), .bus(bus1));
  sync_filt_edge #(.CH_NUM(1), .SYNC_STAGES(3), .FILT_CNT(1), .RST_VAL(1'b0))
    dut2 (.clk(clk), .rst_n(rst2_n), .bus(bus2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic hist [0:40];
  logic ef, ef_prev, v;

  initial begin
    rst0_n = 1'b0; rst1_n = 1'b0; rst2_n = 1'b0;
    bus0.async_in = '0;    bus0.evt_clr = '0;
    bus1.async_in = 4'hF;  bus1.evt_clr = '0;
    bus2.async_in = '0;    bus2.evt_clr = '0;
    step(3);

    // reset state
    chk("rst_sync", 32'(bus0.sync_out), 0);
    chk("rst_filt", 32'(bus0.filt_out), 0);
    chk("rst_pls",  32'(bus0.rise_pls | bus0.fall_pls), 0);
    chk("rst_stky", 32'(bus0.evt_sticky), 0);

    // ch0 rising edge, default latency
    rst0_n = 1'b1;
    bus0.async_in[0] = 1'b1;
    step(1); chk("a_sync_e1", 32'(bus0.sync_out[0]), 0);
    step(1); chk("a_sync_e2", 32'(bus0.sync_out[0]), 1);
             chk("a_filt_e2", 32'(bus0.filt_out[0]), 0);
    step(3); chk("a_filt_e5", 32'(bus0.filt_out[0]), 0);
             chk("a_rise_e5", 32'(bus0.rise_pls[0]), 0);
    step(1); chk("a_filt_e6", 32'(bus0.filt_out[0]), 1);
             chk("a_rise_e6", 32'(bus0.rise_pls[0]), 1);
             chk("a_fall_e6", 32'(bus0.fall_pls[0]), 0);
             chk("a_stky_e6", 32'(bus0.evt_sticky[0]), 1);
    step(1); chk("a_rise_e7", 32'(bus0.rise_pls[0]), 0);
             chk("a_stky_e7", 32'(bus0.evt_sticky[0]), 1);

    // ch1 three-cycle glitch
    bus0.async_in[1] = 1'b1;
    step(2); chk("b_sync_g2", 32'(bus0.sync_out[1]), 1);
    step(1); bus0.async_in[1] = 1'b0;
    step(1); chk("b_sync_g4", 32'(bus0.sync_out[1]), 1);
             chk("b_cnt_g4",  32'(dut0.cnt_q[1]), 2);
    step(1); chk("b_sync_g5", 32'(bus0.sync_out[1]), 0);
             chk("b_cnt_g5",  32'(dut0.cnt_q[1]), 3);
    for (int k = 0; k < 4; k++) begin
      step(1);
      chk("b_filt", 32'(bus0.filt_out[1]), 0);
      chk("b_rise", 32'(bus0.rise_pls[1]), 0);
    end
    chk("b_stky", 32'(bus0.evt_sticky[1]), 0);
    chk("b_cnt",  32'(dut0.cnt_q[1]), 0);

    // ch2 settle high, clear, then fall and clear interplay
    bus0.async_in[2] = 1'b1;
    step(8); chk("c_filt_hi", 32'(bus0.filt_out[2]), 1);
             chk("c_stky_hi", 32'(bus0.evt_sticky[2]), 1);
    bus0.evt_clr[2] = 1'b1;
    step(1); bus0.evt_clr[2] = 1'b0;
             chk("c_stky_clr", 32'(bus0.evt_sticky[2]), 0);
    bus0.async_in[2] = 1'b0;
    step(5); chk("c_fall_f5", 32'(bus0.fall_pls[2]), 0);
             chk("c_filt_f5", 32'(bus0.filt_out[2]), 1);
    step(1); chk("c_fall_f6", 32'(bus0.fall_pls[2]), 1);
             chk("c_rise_f6", 32'(bus0.rise_pls[2]), 0);
             chk("c_filt_f6", 32'(bus0.filt_out[2]), 0);
             chk("c_stky_f6", 32'(bus0.evt_sticky[2]), 1);
    bus0.evt_clr[2] = 1'b1;
    step(1); chk("c_fall_f7", 32'(bus0.fall_pls[2]), 0);
             chk("c_stky_f7", 32'(bus0.evt_sticky[2]), 0);
    bus0.async_in[2] = 1'b1;
    step(5); chk("c_stky_r5", 32'(bus0.evt_sticky[2]), 0);
    step(1); chk("c_rise_r6", 32'(bus0.rise_pls[2]), 1);
             chk("c_stky_r6", 32'(bus0.evt_sticky[2]), 1);
    step(1); chk("c_stky_r7", 32'(bus0.evt_sticky[2]), 0);
    bus0.evt_clr[2] = 1'b0;
    chk("c_stky_ch0", 32'(bus0.evt_sticky[0]), 1);

    // ch3 reset in the middle of filtering
    bus0.async_in = '0;
    step(8);
    bus0.async_in[3] = 1'b1;
    step(3); chk("d_cnt_d3", 32'(dut0.cnt_q[3]), 1);
    rst0_n = 1'b0;
    step(1); chk("d_rst_filt", 32'(bus0.filt_out), 0);
             chk("d_rst_sync", 32'(bus0.sync_out), 0);
             chk("d_rst_cnt",  32'(dut0.cnt_q[3]), 0);
             chk("d_rst_stky", 32'(bus0.evt_sticky), 0);
    rst0_n = 1'b1;
    step(1); chk("d_pls_rel1", 32'(bus0.rise_pls | bus0.fall_pls), 0);
             chk("d_sync_rel1", 32'(bus0.sync_out[3]), 0);
    step(4); chk("d_filt_rel5", 32'(bus0.filt_out[3]), 0);
    step(1); chk("d_filt_rel6", 32'(bus0.filt_out[3]), 1);
             chk("d_rise_rel6", 32'(bus0.rise_pls), 4'b1000);

    // non-zero reset value
    chk("e_rst_filt", 32'(bus1.filt_out), 4'hF);
    chk("e_rst_sync", 32'(bus1.sync_out), 4'hF);
    rst1_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step(1);
      chk("e_nopls", 32'(bus1.rise_pls | bus1.fall_pls), 0);
    end
    chk("e_filt", 32'(bus1.filt_out), 4'hF);
    chk("e_stky", 32'(bus1.evt_sticky), 0);
    bus1.async_in = 4'b0101;
    step(5); chk("e_fall_5", 32'(bus1.fall_pls), 0);
    step(1); chk("e_fall_6", 32'(bus1.fall_pls), 4'b1010);
             chk("e_rise_6", 32'(bus1.rise_pls), 0);
             chk("e_filt_6", 32'(bus1.filt_out), 4'b0101);
             chk("e_stky_6", 32'(bus1.evt_sticky), 4'b1010);
    step(1); chk("e_fall_7", 32'(bus1.fall_pls), 0);

    // corner parameters: filt_out after edge k equals input present at edge k-3
    rst2_n = 1'b1;
    ef_prev = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      v = (((k + 1) / 2) % 2) != 0;
      bus2.async_in = v;
      hist[k] = v;
      step(1);
      ef = (k >= 4) ? hist[k-3] : 1'b0;
      chk("f_filt", 32'(bus2.filt_out), 32'(ef));
      chk("f_rise", 32'(bus2.rise_pls), 32'(ef & ~ef_prev));
      chk("f_fall", 32'(bus2.fall_pls), 32'(~ef & ef_prev));
      chk("f_ovlp", 32'(bus2.rise_pls & bus2.fall_pls), 0);
      ef_prev = ef;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_filt_edge.md
Name: sync_filt_edge

Overview:
- Multi-channel, single-clock input conditioner for asynchronous level signals (straps, buttons, status lines from foreign domains).
- Each channel passes through a parametrised-depth ASYNC_REG flop chain, then a consecutive-sample glitch filter, then registered rise/fall pulse generation and a sticky event flag.
- Sits at the boundary between pins or foreign-domain levels and control logic in the clk domain.

Parameters:
- CH_NUM, 4, number of independent channels (1..32).
- SYNC_STAGES, 2, synchronizer flop depth (2..4); all chain flops carry ASYNC_REG = "TRUE".
- FILT_CNT, 4, consecutive differing samples required before the filtered output changes (1..255); counter width is $clog2(FILT_CNT+1).
- RST_VAL, {CH_NUM{1'b0}}, CH_NUM-bit reset value of sync chain and filt_out.

Ports:
- clk  input  1  sole clock; every flop in the block is clocked by it.
- rst_n  input  1  reset, synchronous, active-low.
- async_in  input  CH_NUM  asynchronous level inputs.
- sync_out  output  CH_NUM  last stage of the synchronizer chain, unfiltered.
- filt_out  output  CH_NUM  debounced level.
- rise_pls  output  CH_NUM  one-cycle pulse when filt_out goes 0->1.
- fall_pls  output  CH_NUM  one-cycle pulse when filt_out goes 1->0.
- evt_clr  input  CH_NUM  per-channel clear of evt_sticky (synchronous to clk).
- evt_sticky  output  CH_NUM  set by any rise or fall pulse, held until cleared.

Behaviour:
- Reset (rst_n=0 at posedge clk):
  - all sync stages and filt_out <= RST_VAL;
  - filter counters <= 0;
  - rise_pls, fall_pls, evt_sticky <= 0.
  - Reset asserted mid-filtering discards the partial count.
  - Reset release itself generates no pulse.
  - An input differing from RST_VAL after release is filtered and reported normally.
- Sync chain: stage0 <= async_in; stage k <= stage k-1; sync_out = stage SYNC_STAGES-1. No reset-value glitch beyond RST_VAL.
- Filter, per channel, every edge:
  - sync_out == filt_out: cnt <= 0.
  - sync_out != filt_out and cnt < FILT_CNT-1: cnt <= cnt+1.
  - sync_out != filt_out and cnt == FILT_CNT-1: filt_out <= sync_out, cnt <= 0 (the "update" event).
- Latency: an input change settled before edge 1 appears on sync_out after edge SYNC_STAGES and on filt_out after edge SYNC_STAGES+FILT_CNT.
- Glitch rejection: a sync_out excursion lasting fewer than FILT_CNT cycles never reaches filt_out, and the counter returns to 0.
- FILT_CNT=1: filt_out is sync_out delayed one cycle.
- Pulses (registered):
  - rise_pls[i] <= update_i & sync_out[i]; fall_pls[i] <= update_i & ~sync_out[i].
  - Each pulse is high for exactly the first cycle the new filt_out value is visible.
  - rise_pls and fall_pls are never high together on one channel.
- Sticky:
  - evt_sticky[i] <= (evt_sticky[i] & ~evt_clr[i]) | rise_pls_next[i] | fall_pls_next[i].
  - Set wins over simultaneous clear, so the flag asserts in the same cycle as the pulse.
  - Holding evt_clr continuously still lets new events set the flag.
- Channels are fully independent; no cross-channel coupling.

Test Plan:
- Defaults (SYNC_STAGES=2, FILT_CNT=4, RST_VAL=0): async_in[0] 0->1 before edge 1 and held -> sync_out[0]=1 after edge 2; filt_out[0]=1 and rise_pls[0]=1 after edge 6; rise_pls[0]=0 after edge 7; evt_sticky[0]=1 from edge 6 on.
- Glitch: async_in[1] high for 3 cycles, then low -> sync_out[1] pulses for 3 cycles; filt_out[1], rise_pls[1] and evt_sticky[1] stay 0; internal cnt returns to 0.
- Falling edge plus clear: channel 2 settled at 1, then async_in[2]->0 -> fall_pls[2]=1 exactly one cycle, 6 edges after the change; evt_clr[2]=1 one cycle later -> evt_sticky[2]=0; evt_clr asserted the same cycle as a new pulse -> evt_sticky stays 1.
- Reset mid-filter: async_in[3]=1, rst_n=0 at edge 4 (cnt=1) -> after release with input held 1, filt_out[3] rises exactly SYNC_STAGES+FILT_CNT edges after release; no pulse at release itself.
- Non-zero reset value (RST_VAL=4'b1111, async_in=4'b1111) -> no pulses after reset. Then async_in=4'b0101 -> fall_pls=4'b1010 for one cycle, 6 edges later.
- Corner parameters (SYNC_STAGES=3, FILT_CNT=1, CH_NUM=1): toggle every 2 cycles -> filt_out follows with 4-edge latency; rise/fall pulses alternate and never overlap.
